// File: rtl/rr_arbiter4.sv
// rtl/rr_arbiter4.sv - four-way round-robin arbiter with bounded hold time
// Grant outputs are registered; a release can hand over to the next winner on the same edge.
module rr_arbiter4 #(
  parameter int MAX_HOLD = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] req,
  output logic [3:0] grant,
  output logic [1:0] grant_idx,
  output logic       grant_valid
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BUSY = 1'b1;

  logic [0:0] state;
  logic [1:0] ptr;
  logic [2:0] hold_cnt;

  logic       release_now;
  logic [1:0] search_base;
  logic [1:0] cand;
  logic       win_found;
  logic [1:0] win_idx;

  always_comb begin
    release_now = (state == ST_BUSY) &&
                  (!req[grant_idx] || !enable || (hold_cnt == 3'(MAX_HOLD)));
    // On release the search already starts past the outgoing owner.
    search_base = release_now ? grant_idx + 2'd1 : ptr;
    win_found   = 1'b0;
    win_idx     = 2'd0;
    cand        = 2'd0;
    // Scan from the farthest offset down so the nearest requester is kept last.
    for (int k = 3; k >= 0; k--) begin
      cand = search_base + 2'(k);
      if (req[cand]) begin
        win_found = 1'b1;
        win_idx   = cand;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= ST_IDLE;
      ptr         <= 2'd0;
      hold_cnt    <= 3'd0;
      grant       <= 4'b0000;
      grant_idx   <= 2'd0;
      grant_valid <= 1'b0;
    end else if (state == ST_IDLE) begin
      if (enable && win_found) begin
        state       <= ST_BUSY;
        hold_cnt    <= 3'd1;
        grant       <= 4'b0001 << win_idx;
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
      end
    end else if (release_now) begin
      ptr <= grant_idx + 2'd1;
      if (enable && win_found) begin
        hold_cnt    <= 3'd1;
        grant       <= 4'b0001 << win_idx;
        grant_idx   <= win_idx;
        grant_valid <= 1'b1;
      end else begin
        state       <= ST_IDLE;
        hold_cnt    <= 3'd0;
        grant       <= 4'b0000;
        grant_idx   <= 2'd0;
        grant_valid <= 1'b0;
      end
    end else begin
      hold_cnt <= hold_cnt + 3'd1;
    end
  end

endmodule

// File: tb/tb_rr_arbiter4.sv
// tb/tb_rr_arbiter4.sv - self-checking bench for rr_arbiter4
// Directed scenarios followed by randomized traffic against an integer reference model.
module tb_rr_arbiter4;

  localparam int MAX_HOLD = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [3:0] req;
  logic [3:0] grant;
  logic [1:0] grant_idx;
  logic       grant_valid;

  int checks = 0;
  int errors = 0;

  int m_owner = -1;
  int m_cnt   = 0;
  int m_ptr   = 0;

  rr_arbiter4 #(.MAX_HOLD(MAX_HOLD)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .req        (req),
    .grant      (grant),
    .grant_idx  (grant_idx),
    .grant_valid(grant_valid)
  );

  always #5 clk = ~clk;

  function automatic int search(input int p, input logic [3:0] r);
    for (int k = 0; k < 4; k++) begin
      if (r[(p + k) % 4]) return (p + k) % 4;
    end
    return -1;
  endfunction

  task automatic model_step(input logic rst, input logic en, input logic [3:0] r);
    int w;
    if (rst) begin
      m_owner = -1; m_cnt = 0; m_ptr = 0;
    end else if (m_owner < 0) begin
      w = en ? search(m_ptr, r) : -1;
      if (w >= 0) begin m_owner = w; m_cnt = 1; end
    end else if (!r[m_owner] || !en || m_cnt == MAX_HOLD) begin
      m_ptr   = (m_owner + 1) % 4;
      m_owner = -1;
      m_cnt   = 0;
      w = en ? search(m_ptr, r) : -1;
      if (w >= 0) begin m_owner = w; m_cnt = 1; end
    end else begin
      m_cnt++;
    end
  endtask

  task automatic check_outputs();
    logic [3:0] exp_g;
    logic [1:0] exp_i;
    logic       exp_v;
    exp_g = (m_owner >= 0) ? 4'(1 << m_owner) : 4'b0000;
    exp_i = (m_owner >= 0) ? 2'(m_owner) : 2'd0;
    exp_v = (m_owner >= 0);
    checks++;
    assert (grant === exp_g) else begin
      errors++; $error("FAIL grant: got %b expected %b", grant, exp_g);
    end
    checks++;
    assert (grant_idx === exp_i) else begin
      errors++; $error("FAIL grant_idx: got %0d expected %0d", grant_idx, exp_i);
    end
    checks++;
    assert (grant_valid === exp_v) else begin
      errors++; $error("FAIL grant_valid: got %b expected %b", grant_valid, exp_v);
    end
    checks++;
    assert ($onehot0(grant) && (grant_valid === (|grant))) else begin
      errors++; $error("FAIL onehot: grant %b valid %b expected onehot0 and valid==|grant", grant, grant_valid);
    end
  endtask

  task automatic tick();
    model_step(reset, enable, req);
    @(posedge clk);
    #1;
    check_outputs();
  endtask

  task automatic expect_grant(input logic [3:0] g, input string tag);
    checks++;
    assert (grant === g) else begin
      errors++; $error("FAIL %s: got %b expected %b", tag, grant, g);
    end
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; req = 4'b0000;
    tick(); tick();
    expect_grant(4'b0000, "reset_state");
    reset = 1'b0;

    // First grant after reset searches from requester 0.
    enable = 1'b1; req = 4'b1010;
    tick();
    expect_grant(4'b0010, "first_grant");

    // Rotation with all requesting: four cycles per owner, no gaps.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1111;
    for (int c = 0; c < 17; c++) begin
      tick();
      expect_grant(4'(1 << ((c / MAX_HOLD) % 4)), "fairness");
    end

    // Owner 2 drops after two cycles; search wraps to requester 0.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b0100;
    tick(); tick();
    expect_grant(4'b0100, "owner2");
    req = 4'b0001;
    tick();
    expect_grant(4'b0001, "early_drop_wrap");

    // Sole requester keeps the grant across hold timeouts.
    req = 4'b0100;
    for (int c = 0; c < 10; c++) tick();
    expect_grant(4'b0100, "sole_requester");

    // Enable falls under owner 3, then returns with ptr wrapped to 0.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1000;
    tick();
    expect_grant(4'b1000, "owner3");
    enable = 1'b0;
    tick();
    expect_grant(4'b0000, "enable_drop");
    enable = 1'b1; req = 4'b1001;
    tick();
    expect_grant(4'b0001, "enable_return");

    // Reset in the middle of a grant.
    reset = 1'b1; tick(); reset = 1'b0;
    req = 4'b1000;
    tick();
    expect_grant(4'b1000, "pre_reset");
    reset = 1'b1;
    tick();
    expect_grant(4'b0000, "mid_reset");
    reset = 1'b0;
    tick();
    expect_grant(4'b1000, "post_reset");

    // Randomized traffic.
    for (int c = 0; c < 600; c++) begin
      reset  = ($urandom_range(0, 59) == 0);
      enable = ($urandom_range(0, 9) != 0);
      if ($urandom_range(0, 3) == 0) req = 4'($urandom);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
